// File: rtl/apb3_pkg.sv
// Shared definitions for the APB3 initiator: FSM state encoding, the default
// ACCESS-phase timeout, peripheral register offsets and the counter sizing helper.
package apb3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb3_state_e;

    localparam int TIMEOUT_DEFAULT = 255;

    localparam logic [31:0] OFFSET_SWITCH_STATUS = 32'h0000_0000;
    localparam logic [31:0] OFFSET_SERVO1        = 32'h0000_0010;
    localparam logic [31:0] OFFSET_SERVO2        = 32'h0000_0014;

    // Wait counter width: wide enough to hold TIMEOUT_CYCLES, never below 8 bits.
    function automatic int wait_cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        if (w < 8) begin
            w = 8;
        end
        return w;
    endfunction

endpackage

// File: rtl/apb3_wait_timer.sv
// ACCESS-phase wait counter with timeout compare. The counter is cleared
// while the initiator is in SETUP and counts every ACCESS cycle in which the
// peripheral is not ready. expired_o flags the cycle whose count-up would
// reach TIMEOUT_CYCLES, so the abort lands on exactly that edge.
module apb3_wait_timer
    import apb3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int            CW       = wait_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic          ENABLED  = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = ENABLED && count_en_i && (count_q == LAST_CNT);

endmodule

// File: rtl/apb3_initiator.sv
// APB3 initiator: converts one command at a time into an APB3 SETUP/ACCESS
// transfer and returns a single response. Every output is driven from a flop.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. Payload is held stable while valid
// is high and the transfer has not happened; cmd_valid is ignored outside IDLE.
module apb3_initiator
    import apb3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output apb3_state_e dbg_state_o
);

    apb3_state_e state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign timer_clear = (state_q == ST_SETUP);
    assign timer_en    = (state_q == ST_ACCESS) && !PREADY;

    apb3_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .clear_i    (timer_clear),
        .count_en_i (timer_en),
        .expired_o  (timer_expired)
    );

    // Next-state and next-output logic; everything holds unless a phase ends.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                // A ready peripheral wins over a timeout on the same edge.
                if (PREADY) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? 32'h0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer without a response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 32'h0;
            pwdata_q      <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb3_initiator.sv
// Bench for apb3_initiator: table of directed transfers, a randomized run
// against a transfer-level model, and hand sequences for response
// backpressure, the disabled timeout and reset in the middle of ACCESS.
module tb_apb3_initiator;
    import apb3_pkg::*;

    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    // ---------------- DUT with TIMEOUT_CYCLES = 8 ----------------
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;
    apb3_state_e dbg_state;

    apb3_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .dbg_state_o(dbg_state)
    );

    // ---------------- DUT with timeout disabled ----------------
    logic        cmd_valid0 = 1'b0;
    logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
    logic        rsp_ready0 = 1'b0;
    logic [31:0] rsp_rdata0;
    logic        PSEL0, PENABLE0, PWRITE0;
    logic [31:0] PADDR0, PWDATA0;
    logic [31:0] PRDATA0 = '0;
    logic        PREADY0 = 1'b0;
    apb3_state_e dbg_state0;

    apb3_initiator #(.TIMEOUT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(1'b0),
        .cmd_addr(OFFSET_SERVO2), .cmd_wdata(32'h0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0),
        .PSEL(PSEL0), .PENABLE(PENABLE0), .PWRITE(PWRITE0), .PADDR(PADDR0),
        .PWDATA(PWDATA0), .PRDATA(PRDATA0), .PREADY(PREADY0), .PSLVERR(1'b0),
        .dbg_state_o(dbg_state0)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    // packed expectation: {timeout, err, rdata[31:0], access_cycles[7:0]}
    logic [41:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [41:0] pack(input logic to, input logic err,
                                         input logic [31:0] rd, input int acc);
        logic [7:0] a;
        a = acc[7:0];
        return {to, err, rd, a};
    endfunction

    // Transfer-level model: a transfer lasts waits+1 ACCESS cycles unless the
    // peripheral is still not ready after TMO cycles, in which case it aborts.
    function automatic logic [41:0] model(input logic wr, input logic [31:0] rdata,
                                          input logic slverr, input int waits);
        if (TMO != 0 && waits >= TMO) return pack(1'b1, 1'b1, 32'h0, TMO);
        return pack(1'b0, slverr, wr ? 32'h0 : rdata, waits + 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer on the TMO=8 DUT, acting as both command source,
    // APB peripheral (ready after 'waits' stalled cycles) and response sink.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdata, input logic slverr,
                           input int rsp_delay, input bit hold_cmd);
        int guard;
        int acc;
        logic [41:0] exp;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        check("setup_ctrl", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b1000);
        check("setup_addr", PADDR, addr);
        check("setup_wdata", PWDATA, wdata);
        check("setup_write", PWRITE, wr);
        step();
        check("access_ctrl", {PSEL, PENABLE, rsp_valid}, 3'b110);
        acc = 0;
        while (PSEL && PENABLE && acc < 300) begin
            acc++;
            PREADY  = (acc > waits);
            PRDATA  = (acc > waits) ? rdata : $urandom;
            PSLVERR = (acc > waits) ? slverr : 1'($urandom);
            check("access_addr_stable", {PWRITE, PADDR, PWDATA}, {wr, addr, wdata});
            step();
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        check("resp_ctrl", {PSEL, PENABLE, rsp_valid}, 3'b001);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow actual=0 expected=1");
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
            check("resp_payload", {rsp_timeout, rsp_err, rsp_rdata, acc[7:0]}, exp);
        end
        for (int d = 0; d < rsp_delay; d++) begin
            rsp_ready = 1'b0;
            if (hold_cmd) begin
                cmd_valid = 1'b1; cmd_addr = 32'hDEAD_0000; cmd_write = ~wr;
            end
            step();
            check("resp_hold", {rsp_valid, rsp_timeout, rsp_err, rsp_rdata}, {1'b1, exp[41:8]});
            check("resp_no_accept", {cmd_ready, PSEL, PENABLE}, 3'b000);
            check("resp_apb_held", {PWRITE, PADDR}, {wr, addr});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("resp_done", {rsp_valid, cmd_ready}, 2'b01);
        check("resp_done_state", dbg_state, ST_IDLE);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        int          rsp_delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : main
        int saw;
        int bad;
        logic        r_wr;
        logic [31:0] r_addr, r_wdata, r_rdata;
        logic        r_err;
        int          r_waits, r_delay;

        //            wr    addr           wdata         waits rdata         err   dly  exp_rdata     e_err e_to acc
        vecs[0] = '{1'b1, OFFSET_SERVO1, 32'h0000_005A, 0,  32'hFFFF_FFFF, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, OFFSET_SWITCH_STATUS, 32'h0,  3,  32'h0000_0003, 1'b0, 1, 32'h0000_0003, 1'b0, 1'b0, 4};
        vecs[2] = '{1'b1, OFFSET_SERVO2, 32'h0000_1234, 0,  32'h0000_0042, 1'b1, 0, 32'h0,        1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, OFFSET_SERVO1, 32'h0,        20,  32'h0000_AAAA, 1'b0, 2, 32'h0,        1'b1, 1'b1, 8};
        vecs[4] = '{1'b0, OFFSET_SERVO2, 32'h0,         7,  32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 8};
        vecs[5] = '{1'b0, OFFSET_SWITCH_STATUS, 32'h0,  8,  32'h0000_0055, 1'b0, 0, 32'h0,        1'b1, 1'b1, 8};
        vecs[6] = '{1'b0, OFFSET_SWITCH_STATUS, 32'h0,  1,  32'h0000_0099, 1'b1, 1, 32'h0000_0099, 1'b1, 1'b0, 2};
        vecs[7] = '{1'b1, OFFSET_SERVO1, 32'h0000_FFFF, 2,  32'h1111_2222, 1'b0, 0, 32'h0,        1'b0, 1'b0, 3};

        // reset
        PRESET = 1'b1;
        step(); step(); step();
        check("rst_ctrl", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE}, 7'b1000000);
        check("rst_data", {PADDR, PWDATA}, 64'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_state", dbg_state, ST_IDLE);
        PRESET = 1'b0;
        step();
        check("idle_after_rst", {cmd_ready, PSEL}, 2'b10);

        // table-driven transfers
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pack(vecs[i].exp_to, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_acc));
            do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                    vecs[i].rdata, vecs[i].slverr, vecs[i].rsp_delay, 1'b0);
        end

        // response backpressure with a pending command, then immediate acceptance
        exp_q.push_back(model(1'b1, 32'h0, 1'b0, 0));
        do_xfer(1'b1, OFFSET_SERVO2, 32'h0000_0077, 0, 32'h0, 1'b0, 5, 1'b1);
        exp_q.push_back(model(1'b0, 32'h0000_0003, 1'b0, 0));
        do_xfer(1'b0, OFFSET_SWITCH_STATUS, 32'h0, 0, 32'h0000_0003, 1'b0, 0, 1'b0);

        // randomized transfers against the model
        for (int n = 0; n < 40; n++) begin
            r_wr    = 1'($urandom);
            r_addr  = ($urandom_range(0, 3) == 0) ? $urandom : OFFSET_SERVO1 + 32'($urandom_range(0, 1) * 4);
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_err   = ($urandom_range(0, 4) == 0);
            r_waits = $urandom_range(0, 11);
            r_delay = $urandom_range(0, 3);
            exp_q.push_back(model(r_wr, r_rdata, r_err, r_waits));
            do_xfer(r_wr, r_addr, r_wdata, r_waits, r_rdata, r_err, r_delay, 1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;

        // timeout disabled: ACCESS must persist for 1000 cycles
        check("t0_idle", {cmd_ready0, PSEL0}, 2'b10);
        cmd_valid0 = 1'b1;
        step();
        cmd_valid0 = 1'b0;
        check("t0_setup", {PSEL0, PENABLE0, PADDR0}, {2'b10, OFFSET_SERVO2});
        step();
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            if (!(PSEL0 && PENABLE0) || rsp_valid0) bad++;
            step();
        end
        check("t0_no_abort", bad, 0);
        PREADY0 = 1'b1; PRDATA0 = 32'h0000_1234;
        step();
        PREADY0 = 1'b0;
        check("t0_resp", {rsp_valid0, rsp_err0, rsp_timeout0, rsp_rdata0, PSEL0}, {3'b100, 32'h0000_1234, 1'b0});
        rsp_ready0 = 1'b1;
        step();
        rsp_ready0 = 1'b0;
        check("t0_back_idle", {rsp_valid0, cmd_ready0}, 2'b01);

        // reset pulsed during ACCESS aborts silently
        cmd_write = 1'b1; cmd_addr = OFFSET_SERVO1; cmd_wdata = 32'h0000_00AA; cmd_valid = 1'b1;
        PREADY = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_access", {PSEL, PENABLE}, 2'b11);
        step(); step();
        PRESET = 1'b1;
        step();
        check("rst_access_apb", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
        check("rst_access_addr", PADDR, 32'h0);
        PRESET = 1'b0;
        saw = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (rsp_valid || !cmd_ready || PSEL) saw++;
        end
        check("rst_access_silent", saw, 0);

        // normal operation resumes after reset
        exp_q.push_back(model(1'b0, 32'h0BAD_F00D, 1'b0, 2));
        do_xfer(1'b0, OFFSET_SERVO2, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
